// File: rtl/vga_pkg.sv
`default_nettype none
// vga_pkg: default display geometry and the motion FSM encoding shared by the logo mover.
package vga_pkg;

   localparam int unsigned DISPLAY_WIDTH  = 640;
   localparam int unsigned DISPLAY_HEIGHT = 480;
   localparam int unsigned LOGO_SIZE      = 128;
   localparam int unsigned POS_W          = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_DONE = 2'd2
   } motion_state_e;

   // Palette advance for one step: a corner hit counts both walls.
   function automatic logic [2:0] hit_count(input logic hit_a, input logic hit_b);
      return {2'b00, hit_a} + {2'b00, hit_b};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bounce_axis.sv
`default_nettype none
// bounce_axis: one axis of the bouncing logo -- position, direction and wall-hit detect.
module bounce_axis #(
   parameter int unsigned MAX      = 512,
   parameter int unsigned INIT_POS = 200,
   parameter logic        INIT_DIR = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       step_i,
   output logic [9:0] pos_o,
   output logic       dir_o,
   output logic       hit_o
);
   import vga_pkg::*;

   localparam logic [POS_W-1:0] MAX_POS  = POS_W'(MAX);
   localparam logic [POS_W-1:0] INIT_VAL = POS_W'(INIT_POS);

   logic [POS_W-1:0] pos_q, pos_d;
   logic             dir_q, dir_d;
   logic             hit;

   // A wall hit reflects the direction and moves one pixel back inside,
   // so the position never leaves [0, MAX].
   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      hit   = 1'b0;
      if (step_i) begin
         if (!dir_q && pos_q == '0) begin
            dir_d = 1'b1;
            pos_d = POS_W'(1);
            hit   = 1'b1;
         end else if (dir_q && pos_q == MAX_POS) begin
            dir_d = 1'b0;
            pos_d = MAX_POS - POS_W'(1);
            hit   = 1'b1;
         end else if (dir_q) begin
            pos_d = pos_q + POS_W'(1);
         end else begin
            pos_d = pos_q - POS_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q <= INIT_VAL;
         dir_q <= INIT_DIR;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign pos_o = pos_q;
   assign dir_o = dir_q;
   assign hit_o = hit;

endmodule
`default_nettype wire

// File: rtl/logo_motion_ctrl.sv
`default_nettype none
// logo_motion_ctrl: per-frame bouncing-logo position update, one pixel per axis per STEP cycle.
module logo_motion_ctrl #(
   parameter int unsigned LOGO_SIZE      = vga_pkg::LOGO_SIZE,
   parameter int unsigned DISPLAY_WIDTH  = vga_pkg::DISPLAY_WIDTH,
   parameter int unsigned DISPLAY_HEIGHT = vga_pkg::DISPLAY_HEIGHT,
   parameter int unsigned INIT_LEFT      = 200,
   parameter int unsigned INIT_TOP       = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic [1:0] speed,
   output logic [9:0] logo_left,
   output logic [9:0] logo_top,
   output logic       dir_x,
   output logic       dir_y,
   output logic [2:0] color_index,
   output logic       pos_valid,
   output logic       bounce,
   output logic       overrun
);
   import vga_pkg::*;

   localparam int unsigned MAX_X = DISPLAY_WIDTH - LOGO_SIZE;
   localparam int unsigned MAX_Y = DISPLAY_HEIGHT - LOGO_SIZE;

   motion_state_e state_q;
   logic [1:0]    cnt_q;
   logic          hit_q;
   logic [2:0]    color_q;
   logic          bounce_q;
   logic          overrun_q;
   logic          valid_q;

   logic          step_en;
   logic          hit_x;
   logic          hit_y;

   assign step_en = (state_q == ST_STEP);

   bounce_axis #(
      .MAX      (MAX_X),
      .INIT_POS (INIT_LEFT),
      .INIT_DIR (1'b1)
   ) u_axis_x (
      .clk    (clk),
      .rst_n  (rst_n),
      .step_i (step_en),
      .pos_o  (logo_left),
      .dir_o  (dir_x),
      .hit_o  (hit_x)
   );

   bounce_axis #(
      .MAX      (MAX_Y),
      .INIT_POS (INIT_TOP),
      .INIT_DIR (1'b0)
   ) u_axis_y (
      .clk    (clk),
      .rst_n  (rst_n),
      .step_i (step_en),
      .pos_o  (logo_top),
      .dir_o  (dir_y),
      .hit_o  (hit_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 2'd0;
         hit_q     <= 1'b0;
         color_q   <= 3'd0;
         bounce_q  <= 1'b0;
         overrun_q <= 1'b0;
         valid_q   <= 1'b1;
      end else begin
         bounce_q <= 1'b0;
         if (frame_tick && state_q != ST_IDLE) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (frame_tick && enable && speed != 2'd0) begin
                  cnt_q   <= speed;
                  hit_q   <= 1'b0;
                  valid_q <= 1'b0;
                  state_q <= ST_STEP;
               end
            end
            ST_STEP: begin
               color_q <= color_q + hit_count(hit_x, hit_y);
               hit_q   <= hit_q | hit_x | hit_y;
               cnt_q   <= cnt_q - 2'd1;
               // bounce is loaded on entry to DONE so it is high exactly for that cycle.
               if (cnt_q == 2'd1) begin
                  bounce_q <= hit_q | hit_x | hit_y;
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: begin
               valid_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               valid_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign color_index = color_q;
   assign pos_valid   = valid_q;
   assign bounce      = bounce_q;
   assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: doc/logo_motion_ctrl.md
LOGO_MOTION_CTRL -- requirements
Module: logo_motion_ctrl

Interface
REQ-001 SHALL have parameter LOGO_SIZE, default 128, logo edge length in pixels.
REQ-002 SHALL have parameter DISPLAY_WIDTH, default 640, visible width in pixels.
REQ-003 SHALL have parameter DISPLAY_HEIGHT, default 480, visible height in pixels.
REQ-004 SHALL have parameter INIT_LEFT, default 200, reset X position.
REQ-005 SHALL have parameter INIT_TOP, default 200, reset Y position.
REQ-006 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port frame_tick  input  1  one-cycle pulse per frame (e.g. first pixel of line 0).
REQ-009 SHALL have port enable  input  1  motion enable; 0 freezes position.
REQ-010 SHALL have port speed  input  2  pixels moved per frame per axis (0 = none, 1..3).
REQ-011 SHALL have port logo_left  output  10  current logo X.
REQ-012 SHALL have port logo_top  output  10  current logo Y.
REQ-013 SHALL have port dir_x  output  1  1 = moving right.
REQ-014 SHALL have port dir_y  output  1  1 = moving down.
REQ-015 SHALL have port color_index  output  3  palette index, bumped per wall hit.
REQ-016 SHALL have port pos_valid  output  1  1 when position is stable (IDLE).
REQ-017 SHALL have port bounce  output  1  one-cycle pulse when a frame update included a wall hit.
REQ-018 SHALL have port overrun  output  1  sticky; set when frame_tick arrives outside IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> STEP -> DONE -> IDLE.
REQ-020 IDLE: frame_tick=1 with enable=1 and speed!=0 SHALL load step counter with speed, clear hit flag, go to STEP; otherwise stay IDLE.
REQ-021 STEP: each cycle SHALL move both axes by exactly one pixel, decrement step counter, go to DONE when counter reaches 1 (speed cycles in STEP).
REQ-022 MAX_X = DISPLAY_WIDTH-LOGO_SIZE (512), MAX_Y = DISPLAY_HEIGHT-LOGO_SIZE (352), computed at elaboration.
REQ-023 X step: dir_x=0 and logo_left==0 -> dir_x<=1, logo_left<=1, hit; dir_x=1 and logo_left==MAX_X -> dir_x<=0, logo_left<=MAX_X-1, hit; else logo_left±1.
REQ-024 Y step SHALL follow REQ-023 with logo_top, dir_y, MAX_Y.
REQ-025 color_index SHALL increment mod 8 by number of axes hitting in that cycle (corner hit = +2).
REQ-026 Positions SHALL never leave [0,MAX_X] / [0,MAX_Y]; all arithmetic 10-bit, no wrap.
REQ-027 DONE: bounce SHALL be 1 for exactly this cycle iff any hit occurred in the preceding STEP cycles; return to IDLE.
REQ-028 pos_valid SHALL be 1 only in IDLE; frame latency from frame_tick to pos_valid = speed+2 cycles.
REQ-029 frame_tick in STEP or DONE SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-030 enable or speed changes during STEP SHALL not affect the update in progress (speed latched in IDLE).
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 rst_n low SHALL asynchronously force: FSM IDLE, logo_left=INIT_LEFT, logo_top=INIT_TOP, dir_x=1, dir_y=0, color_index=0, bounce=0, overrun=0, pos_valid=1.
REQ-033 Reset asserted mid-STEP SHALL abandon the update; no bounce pulse after release.

Structure
REQ-034 Display constants (DISPLAY_WIDTH, DISPLAY_HEIGHT, LOGO_SIZE) and FSM state encoding SHALL live in shared package vga_pkg.
REQ-035 One sub-module bounce_axis (one axis: position, direction, hit; parameter MAX) SHALL be instantiated twice.

Verification
REQ-036 Reset, speed=1, 10 frame_ticks -> logo_left=210, logo_top=190, bounce never asserted.
REQ-037 Preload left=511, dir_x=1, speed=3, one tick -> left steps 512, 511, 510; dir_x=0; color_index+1; bounce one cycle.
REQ-038 Preload left=0,top=0,dir_x=0,dir_y=0, speed=1, tick -> left=1, top=1, dir_x=1, dir_y=1, color_index+2.
REQ-039 speed=2, second frame_tick 1 cycle after first -> overrun=1, position moved 2 only; enable=0 ticks -> no change.
REQ-040 rst_n low during STEP at speed=3 -> outputs at reset values immediately, no bounce after release.
